// File: rtl/game_ctrl.sv
// Pong referee: detects goals from ball pixels, paces serves in frames, tracks points and game over.
// Optional GAME_CTRL_SERVE_ALT_EN: serve direction alternates every point instead of facing the conceder.
module game_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int GOAL_LEFT    = 16,
  parameter int GOAL_RIGHT   = 623
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_n,
  input  logic       vsync,
  input  logic [9:0] hcount,
  input  logic       ball_sig,
  output logic       score_pulse_p1,
  output logic       score_pulse_p2,
  output logic       ball_hold,
  output logic       serve_dir,
  output logic       game_over,
  output logic       winner,
  output logic [3:0] p1_points,
  output logic [3:0] p2_points
);

  localparam logic [9:0] GOAL_L     = 10'(GOAL_LEFT);
  localparam logic [9:0] GOAL_R     = 10'(GOAL_RIGHT);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [3:0] WIN_N      = 4'(WIN_SCORE);

  typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, OVER} state_t;

  state_t     state;
  logic [7:0] serve_cnt;
  logic       goal_l;
  logic       goal_r;
  logic       start_s1;
  logic       start_s2;
  logic       start_s2_d;
  logic       start_press;
  logic       vsync_d;
  logic       frame_tick;
  logic [3:0] p1_next;
  logic [3:0] p2_next;

  // Button is asynchronous, so it is synchronized before edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_s1    <= 1'b1;
      start_s2    <= 1'b1;
      start_s2_d  <= 1'b1;
      start_press <= 1'b0;
      vsync_d     <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      start_s1    <= start_n;
      start_s2    <= start_s1;
      start_s2_d  <= start_s2;
      start_press <= start_s2_d & ~start_s2;
      vsync_d     <= vsync;
      frame_tick  <= vsync_d & ~vsync;
    end
  end

  assign p1_next = (p1_points == 4'd15) ? p1_points : p1_points + 4'd1;
  assign p2_next = (p2_points == 4'd15) ? p2_points : p2_points + 4'd1;

  // Referee FSM; the scorer is remembered by which pulse is high during POINT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      serve_cnt      <= 8'd0;
      goal_l         <= 1'b0;
      goal_r         <= 1'b0;
      score_pulse_p1 <= 1'b0;
      score_pulse_p2 <= 1'b0;
      ball_hold      <= 1'b1;
      serve_dir      <= 1'b1;
      game_over      <= 1'b0;
      winner         <= 1'b0;
      p1_points      <= 4'd0;
      p2_points      <= 4'd0;
    end else begin
      score_pulse_p1 <= 1'b0;
      score_pulse_p2 <= 1'b0;
      case (state)
        IDLE: begin
          if (start_press) begin
            state     <= SERVE;
            serve_cnt <= 8'd0;
            goal_l    <= 1'b0;
            goal_r    <= 1'b0;
          end
        end
        SERVE: begin
          if (frame_tick) begin
            if (serve_cnt == SERVE_LAST) begin
              state     <= PLAY;
              ball_hold <= 1'b0;
            end else begin
              serve_cnt <= serve_cnt + 8'd1;
            end
          end
        end
        PLAY: begin
          if (ball_sig && hcount <= GOAL_L) goal_l <= 1'b1;
          if (ball_sig && hcount >= GOAL_R) goal_r <= 1'b1;
          // A left goal takes priority when both sides were hit in one frame
          if (frame_tick && (goal_l || goal_r)) begin
            state <= POINT;
            if (goal_l) score_pulse_p2 <= 1'b1;
            else        score_pulse_p1 <= 1'b1;
          end
        end
        POINT: begin
          goal_l    <= 1'b0;
          goal_r    <= 1'b0;
          serve_cnt <= 8'd0;
          ball_hold <= 1'b1;
`ifdef GAME_CTRL_SERVE_ALT_EN
          serve_dir <= ~serve_dir;
`else
          serve_dir <= score_pulse_p1;
`endif
          if (score_pulse_p2) begin
            p2_points <= p2_next;
            if (p2_next == WIN_N) begin
              state     <= OVER;
              game_over <= 1'b1;
              winner    <= 1'b1;
            end else begin
              state <= SERVE;
            end
          end else begin
            p1_points <= p1_next;
            if (p1_next == WIN_N) begin
              state     <= OVER;
              game_over <= 1'b1;
              winner    <= 1'b0;
            end else begin
              state <= SERVE;
            end
          end
        end
        OVER: begin
          if (start_press) begin
            state     <= SERVE;
            serve_cnt <= 8'd0;
            p1_points <= 4'd0;
            p2_points <= 4'd0;
            serve_dir <= 1'b1;
            game_over <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: scripted frames push expected score pulses, a monitor pops them.
module tb_game_ctrl;

  localparam int PERIOD       = 10;
  localparam int WIN_SCORE    = 7;
  localparam int SERVE_FRAMES = 60;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       start_n  = 1'b1;
  logic       vsync    = 1'b1;
  logic [9:0] hcount   = '0;
  logic       ball_sig = 1'b0;
  logic       score_pulse_p1;
  logic       score_pulse_p2;
  logic       ball_hold;
  logic       serve_dir;
  logic       game_over;
  logic       winner;
  logic [3:0] p1_points;
  logic [3:0] p2_points;

  typedef struct {
    logic p2;
    time  t;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_p1     = 0;
  int   m_p2     = 0;
  logic m_dir    = 1'b1;
  logic mon_prev = 1'b0;
  exp_t mon_e;

  always #(PERIOD/2) clk = ~clk;

  game_ctrl #(
    .WIN_SCORE(WIN_SCORE),
    .SERVE_FRAMES(SERVE_FRAMES),
    .GOAL_LEFT(16),
    .GOAL_RIGHT(623)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start_n(start_n),
    .vsync(vsync),
    .hcount(hcount),
    .ball_sig(ball_sig),
    .score_pulse_p1(score_pulse_p1),
    .score_pulse_p2(score_pulse_p2),
    .ball_hold(ball_hold),
    .serve_dir(serve_dir),
    .game_over(game_over),
    .winner(winner),
    .p1_points(p1_points),
    .p2_points(p2_points)
  );

  // Pops the scoreboard on every observed pulse and checks player, arrival time and width
  initial begin
    forever begin
      @(negedge clk);
      if (score_pulse_p1 || score_pulse_p2) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL pulse_unexpected: got p1=%b p2=%b at %0t, expected no pulse",
                   score_pulse_p1, score_pulse_p2, $time);
        end else begin
          mon_e = sb.pop_front();
          if ({score_pulse_p1, score_pulse_p2} !== {~mon_e.p2, mon_e.p2} || $time != mon_e.t) begin
            n_fail++;
            $display("[TB] FAIL pulse_match: got p1=%b p2=%b at %0t, expected p1=%b p2=%b at %0t",
                     score_pulse_p1, score_pulse_p2, $time, ~mon_e.p2, mon_e.p2, mon_e.t);
          end
        end
        if (mon_prev) begin
          n_fail++;
          $display("[TB] FAIL pulse_width: got pulse high 2 cycles at %0t, expected 1", $time);
        end
      end
      mon_prev = score_pulse_p1 | score_pulse_p2;
    end
  end

  // One frame: 16 active cycles with optional ball pixels, then vsync low for 2 cycles
  task automatic run_frame(input int hc_a, input int hc_b, input int npx,
                           input logic is_goal, input logic exp_p2);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      vsync = 1'b1; ball_sig = 1'b0; hcount = '0;
      if (i >= 2 && i < 2 + npx) begin
        ball_sig = 1'b1; hcount = 10'(hc_a);
      end else if (hc_b >= 0 && i >= 2 + npx && i < 2 + 2 * npx) begin
        ball_sig = 1'b1; hcount = 10'(hc_b);
      end
    end
    @(negedge clk);
    vsync = 1'b0; ball_sig = 1'b0; hcount = '0;
    if (is_goal) begin
      e.p2 = exp_p2;
      e.t  = $time + 2 * PERIOD;
      sb.push_back(e);
    end
    @(negedge clk);
    @(negedge clk);
    vsync = 1'b1;
  endtask

  task automatic serve_frames(input int n, input logic drop_last);
    logic exp_hold;
    for (int i = 0; i < n; i++) begin
      run_frame(0, -1, 0, 1'b0, 1'b0);
      exp_hold = (drop_last && i == n - 1) ? 1'b0 : 1'b1;
      n_checks++;
      if (ball_hold !== exp_hold) begin
        n_fail++;
        $display("[TB] FAIL serve_hold frame %0d: got %b expected %b", i + 1, ball_hold, exp_hold);
      end
    end
  endtask

  task automatic press_start();
    @(negedge clk);
    start_n = 1'b0;
    repeat (4) @(negedge clk);
    start_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic goal(input int hc_a, input int hc_b, input int npx,
                      input logic exp_p2, input string name);
    logic exp_over;
    run_frame(hc_a, hc_b, npx, 1'b1, exp_p2);
    @(negedge clk);
    if (exp_p2) m_p2++;
    else        m_p1++;
`ifdef GAME_CTRL_SERVE_ALT_EN
    m_dir = ~m_dir;
`else
    m_dir = ~exp_p2;
`endif
    exp_over = (m_p1 == WIN_SCORE) || (m_p2 == WIN_SCORE);
    n_checks++;
    if ({p1_points, p2_points} !== {4'(m_p1), 4'(m_p2)}) begin
      n_fail++;
      $display("[TB] FAIL %s_points: got p1=%0d p2=%0d expected p1=%0d p2=%0d",
               name, p1_points, p2_points, m_p1, m_p2);
    end
    n_checks++;
    if (serve_dir !== m_dir) begin
      n_fail++;
      $display("[TB] FAIL %s_serve_dir: got %b expected %b", name, serve_dir, m_dir);
    end
    n_checks++;
    if ({game_over, ball_hold} !== {exp_over, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL %s_over_hold: got over=%b hold=%b expected over=%b hold=1",
               name, game_over, ball_hold, exp_over);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({score_pulse_p1, score_pulse_p2, ball_hold, serve_dir, game_over, winner, p1_points, p2_points}
        !== {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0}) begin
      n_fail++;
      $display("[TB] FAIL reset_values: got hold=%b dir=%b over=%b p1=%0d p2=%0d expected hold=1 dir=1 over=0 p1=0 p2=0",
               ball_hold, serve_dir, game_over, p1_points, p2_points);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_serve();
    press_start();
    serve_frames(SERVE_FRAMES, 1'b1);
  endtask

  task automatic test_goal_left();
    goal(10, -1, 1, 1'b1, "goal_left");
    serve_frames(SERVE_FRAMES, 1'b1);
  endtask

  task automatic test_multi_line();
    goal(630, -1, 5, 1'b0, "multi_line");
    serve_frames(SERVE_FRAMES, 1'b1);
  endtask

  task automatic test_both_goals();
    goal(10, 630, 2, 1'b1, "both_goals");
  endtask

  task automatic test_reset_mid();
    serve_frames(30, 1'b0);
    @(negedge clk);
    #3 reset = 1'b0;
    #1;
    n_checks++;
    if ({score_pulse_p1, score_pulse_p2, ball_hold, serve_dir, game_over, winner, p1_points, p2_points}
        !== {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0}) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_values: got hold=%b dir=%b over=%b p1=%0d p2=%0d expected hold=1 dir=1 over=0 p1=0 p2=0",
               ball_hold, serve_dir, game_over, p1_points, p2_points);
    end
    @(negedge clk);
    reset = 1'b1;
    m_p1 = 0; m_p2 = 0; m_dir = 1'b1;
    serve_frames(SERVE_FRAMES + 1, 1'b0);
  endtask

  task automatic test_game_over();
    press_start();
    for (int r = 0; r < WIN_SCORE; r++) begin
      serve_frames(SERVE_FRAMES, 1'b1);
      goal(630, -1, 1, 1'b0, "p1_run");
    end
    n_checks++;
    if ({game_over, winner, ball_hold} !== 3'b101) begin
      n_fail++;
      $display("[TB] FAIL game_over_state: got over=%b winner=%b hold=%b expected over=1 winner=0 hold=1",
               game_over, winner, ball_hold);
    end
    serve_frames(2, 1'b0);
    press_start();
    m_p1 = 0; m_p2 = 0; m_dir = 1'b1;
    n_checks++;
    if ({p1_points, p2_points, game_over, ball_hold, serve_dir} !== {8'd0, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL new_game: got p1=%0d p2=%0d over=%b hold=%b dir=%b expected p1=0 p2=0 over=0 hold=1 dir=1",
               p1_points, p2_points, game_over, ball_hold, serve_dir);
    end
    serve_frames(SERVE_FRAMES, 1'b1);
  endtask

  initial begin
    test_reset();
    test_serve();
    test_goal_left();
    test_multi_line();
    test_both_goals();
    test_reset_mid();
    test_game_over();
    repeat (4) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL pending_pulses: got %0d still expected, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Referee state machine for the pong display pipeline. It sits directly upstream of the two `score` instances and alongside `ball`. It watches the ball's pixel signal against the horizontal raster position to detect goals, and emits one-cycle score pulses to the score blocks. It also paces serves in whole video frames and holds the game-over condition until a new game is started.

## Interface
- WIN_SCORE, 7, points that end a game (1..15)
- SERVE_FRAMES, 60, frame ticks the ball is held before each serve (1..255)
- GOAL_LEFT, 16, ball pixel at hcount <= this is a goal against player 1
- GOAL_RIGHT, 623, ball pixel at hcount >= this is a goal against player 2

- clk  in  1  pixel clock (same as vga/ball/score)
- reset  in  1  asynchronous, active-low reset
- start_n  in  1  raw active-low push button (KEY), asynchronous to clk
- vsync  in  1  VGA vertical sync, active-low, synchronous to clk
- hcount  in  10  current pixel column from vga
- ball_sig  in  1  high while the current pixel is a ball pixel
- score_pulse_p1  out  1  one-cycle strobe, player 1 gains a point
- score_pulse_p2  out  1  one-cycle strobe, player 2 gains a point
- ball_hold  out  1  high = ball parked at centre, not moving
- serve_dir  out  1  0 = next serve toward left (player 1), 1 = toward right
- game_over  out  1  high while in OVER
- winner  out  1  0 = player 1, 1 = player 2; valid while game_over
- p1_points, p2_points  out  4 each  current internal point counts

## Operation
- frame_tick: internal one-cycle strobe on the cycle after vsync is registered 1 and then 0 (falling edge).
- start_n passes through a 2-flop synchronizer. start_press is a one-cycle strobe on the synchronized 1→0 edge.
- States:
  - IDLE: ball_hold=1. start_press → SERVE.
  - SERVE: ball_hold=1. Counts frame_ticks from 0. The tick that brings the count to SERVE_FRAMES → PLAY.
  - PLAY: ball_hold=0.
    - Goal flags latch on any cycle where ball_sig is high: goal_l when hcount<=GOAL_LEFT, goal_r when hcount>=GOAL_RIGHT.
    - On frame_tick with either flag set → POINT.
    - If both flags are set, goal_l wins (player 2 scores).
  - POINT: exactly one cycle.
    - The scoring player's pulse is high.
    - That player's counter increments (4-bit, saturates at 15).
    - serve_dir updates.
    - Goal flags clear.
    - If the incremented count == WIN_SCORE → OVER, with winner set to the scorer. Otherwise → SERVE.
  - OVER: ball_hold=1, game_over=1. start_press clears both counters → SERVE.
- start_press in SERVE, PLAY or POINT is ignored.
- Goal flags are cleared on entry to SERVE and never latch outside PLAY.
- Reset values:
  - State IDLE, all counters and flags 0.
  - score_pulse_p1/p2=0, ball_hold=1, serve_dir=1, game_over=0, winner=0, p1/p2_points=0.

## Timing
- Goal-to-pulse latency: the pulse rises 1 clk after the first frame_tick following the goal pixel. That frame_tick is itself vsync fall + 1.
- At most one score pulse per frame. A pulse is never wider than 1 cycle.
- The OVER or SERVE state is visible the cycle after the pulse.
- Serve hold lasts exactly SERVE_FRAMES frame_ticks. ball_hold falls 1 clk after the last tick.
- start_press lands 3 clks after the start_n fall; the state changes on the following edge.
- An asynchronous reset mid-game returns to IDLE immediately with counters cleared. A pulse in flight is dropped.

## Configuration
- GAME_CTRL_SERVE_ALT_EN undefined: in POINT, serve_dir points toward the player who conceded (player 1 scored → 1, player 2 scored → 0).
- GAME_CTRL_SERVE_ALT_EN defined: serve_dir toggles on every POINT regardless of scorer. It is still reset to 1 and still cleared to 1 on new-game start.

## Test plan
- Reset then start_n low for 4 clks → SERVE; ball_hold stays 1 for exactly 60 frame_ticks, then 0.
- In PLAY, ball_sig high at hcount=10 → score_pulse_p2 high 1 cycle after the next frame_tick; p2_points=1; serve_dir=0 (macro undefined).
- Ball pixels at hcount=630 on 5 consecutive lines of one frame → exactly one score_pulse_p1; p1_points=1.
- Goal_l and goal_r in the same frame → only score_pulse_p2.
- Seven player-1 goals → game_over=1, winner=0, ball_hold=1. start_press → p1_points=p2_points=0, SERVE.
- Reset asserted during SERVE frame 30 → all outputs at reset values. start_press is needed to resume.
- With GAME_CTRL_SERVE_ALT_EN, two successive player-1 points → serve_dir goes 1→0→1.
